gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Purpose: sweeps all four input combinations of a 2-input gate and compares its output against a truth table.
// Latency: done pulses 4*(HOLD_CYCLES+1) cycles after start is captured (earlier under GATE_SWEEP_STOP_ON_FAIL_EN on a mismatch).
// Backpressure: none; start is sampled only when idle and ignored while busy or in the done cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             sweep request (sampled only in IDLE)
//   truth[3:0]        expected gate output per combination index
//   dut_out           output of the gate under control
//   drv_a, drv_b      registered gate inputs, {drv_a,drv_b} == idx
//   busy, done        sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt, fail_vec   sweep result, held until the next accepted start
//
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN -- end the sweep at the first mismatching combination.

module gate_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth,
  input  logic       dut_out,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [3:0] hold_cnt;
  logic       mismatch;

  assign mismatch = (dut_out != truth[idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE:  if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE;
      SAMPLE: begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        // First failing combination ends the sweep; later ones stay untested.
        if (mismatch || idx == 2'd3) state_nxt = DONE;
        else                         state_nxt = DRIVE;
`else
        if (idx == 2'd3) state_nxt = DONE;
        else             state_nxt = DRIVE;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 2'd0;
      hold_cnt <= 4'd0;
      drv_a    <= 1'b0;
      drv_b    <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= 2'd0;
            hold_cnt <= 4'd0;
            drv_a    <= 1'b0;
            drv_b    <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
          end
        end
        DRIVE: hold_cnt <= hold_cnt + 4'd1;
        SAMPLE: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            // Only four samples per sweep, but saturate anyway so it can never wrap.
            if (err_cnt != 3'd4) err_cnt <= err_cnt + 3'd1;
          end
          if (state_nxt == DRIVE) begin
            idx            <= idx + 2'd1;
            {drv_a, drv_b} <= idx + 2'd1;
            hold_cnt       <= 4'd0;
          end else begin
            // Final sample counts toward pass as well as the earlier ones.
            pass <= (err_cnt == 3'd0) && !mismatch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] truth;
  logic [3:0] gate_tt;   // behaviour of the emulated gate: output = gate_tt[{a,b}]

  logic       start1, dut_out1, drv_a1, drv_b1, busy1, done1, pass1;
  logic [2:0] err_cnt1;
  logic [3:0] fail_vec1;
  logic       start2, dut_out2, drv_a2, drv_b2, busy2, done2, pass2;
  logic [2:0] err_cnt2;
  logic [3:0] fail_vec2;

  assign dut_out1 = gate_tt[{drv_a1, drv_b1}];
  assign dut_out2 = gate_tt[{drv_a2, drv_b2}];

  gate_sweep_ctrl #(.HOLD_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .truth(truth), .dut_out(dut_out1),
    .drv_a(drv_a1), .drv_b(drv_b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .fail_vec(fail_vec1)
  );

  gate_sweep_ctrl #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .truth(truth), .dut_out(dut_out2),
    .drv_a(drv_a2), .drv_b(drv_b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .fail_vec(fail_vec2)
  );

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic set_start(input int which, input logic v);
    if (which == 1) start1 = v;
    else            start2 = v;
  endtask

  task automatic obs(input int which, output logic b, output logic d, output logic p,
                     output logic [1:0] drv, output logic [2:0] e, output logic [3:0] f);
    if (which == 1) begin
      b = busy1; d = done1; p = pass1; drv = {drv_a1, drv_b1}; e = err_cnt1; f = fail_vec1;
    end else begin
      b = busy2; d = done2; p = pass2; drv = {drv_a2, drv_b2}; e = err_cnt2; f = fail_vec2;
    end
  endtask

  // One sweep on instance `which`, checked every cycle against expectations derived
  // from the sweep rules: combination j is sampled at edge (j+1)*(H+1) after capture.
  task automatic sweep(input int which, input logic [3:0] t, input logic [3:0] g,
                       input bit restarts, input bit start_after_done, input string name);
    int h, k, ncomb, tdone, ndone, ns;
    logic [3:0] mism, ef, m;
    logic [2:0] ee;
    logic ep;
    logic b, d, p;
    logic [1:0] drv, edrv;
    logic [2:0] e_o;
    logic [3:0] f_o;
    h = (which == 1) ? 4 : 2;
    mism = t ^ g;
    k = 4;
    for (int i = 3; i >= 0; i--) if (mism[i]) k = i;
    ncomb = (STOP_ON_FAIL && k < 4) ? k + 1 : 4;
    tdone = ncomb * (h + 1);
    ep = (mism == 4'd0);
    ndone = 0;

    truth = t; gate_tt = g;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    obs(which, b, d, p, drv, e_o, f_o);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL %s capture busy got %b want 1", name, b); end
    checks++; if ({drv, e_o, f_o, p, d} !== 11'd0) begin errors++;
      $display("FAIL %s capture state got drv=%b err=%0d fail=%b pass=%b done=%b want all 0", name, drv, e_o, f_o, p, d); end

    for (int ed = 1; ed <= tdone + 1; ed++) begin
      set_start(which, (restarts && (ed == 3 || ed == 12)) || (start_after_done && ed == tdone + 1));
      @(posedge clk); #1;
      set_start(which, 1'b0);
      obs(which, b, d, p, drv, e_o, f_o);
      if (d === 1'b1) ndone++;
      ns = (ed < tdone) ? ed / (h + 1) : ncomb;
      m = 4'((1 << ns) - 1);
      ef = mism & m;
      ee = 3'($countones(ef));
      edrv = 2'(((ed < tdone) ? ed : tdone - 1) / (h + 1));
      checks++; if (b !== (ed <= tdone)) begin errors++; $display("FAIL %s busy edge %0d got %b want %b", name, ed, b, ed <= tdone); end
      checks++; if (d !== (ed == tdone)) begin errors++; $display("FAIL %s done edge %0d got %b want %b", name, ed, d, ed == tdone); end
      checks++; if (drv !== edrv) begin errors++; $display("FAIL %s drv edge %0d got %b want %b", name, ed, drv, edrv); end
      checks++; if (e_o !== ee) begin errors++; $display("FAIL %s err_cnt edge %0d got %0d want %0d", name, ed, e_o, ee); end
      checks++; if (f_o !== ef) begin errors++; $display("FAIL %s fail_vec edge %0d got %b want %b", name, ed, f_o, ef); end
      checks++; if (p !== ((ed >= tdone) ? ep : 1'b0)) begin errors++;
        $display("FAIL %s pass edge %0d got %b want %b", name, ed, p, (ed >= tdone) ? ep : 1'b0); end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL %s done pulses got %0d want 1", name, ndone); end
  endtask

  task automatic test_reset();
    logic b, d, p;
    logic [1:0] drv;
    logic [2:0] e_o;
    logic [3:0] f_o;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int w = 1; w <= 2; w++) begin
      obs(w, b, d, p, drv, e_o, f_o);
      checks++; if ({b, d, p, drv, e_o, f_o} !== 13'd0) begin errors++;
        $display("FAIL reset inst%0d got busy=%b done=%b pass=%b drv=%b err=%0d fail=%b want all 0", w, b, d, p, drv, e_o, f_o); end
    end
  endtask

  task automatic test_reset_mid();
    logic b, d, p;
    logic [1:0] drv;
    logic [2:0] e_o;
    logic [3:0] f_o;
    int ndone;
    ndone = 0;
    truth = 4'b0111; gate_tt = 4'b1000;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int ed = 1; ed <= 8; ed++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) ndone++;
    end
    checks++; if (err_cnt1 !== 3'd1) begin errors++; $display("FAIL rst_mid pre-reset err_cnt got %0d want 1", err_cnt1); end
    rst = 1'b1;
    start1 = 1'b1;   // reset must win over start
    @(posedge clk); #1;
    rst = 1'b0;
    start1 = 1'b0;
    obs(1, b, d, p, drv, e_o, f_o);
    checks++; if ({b, d, p, drv, e_o, f_o} !== 13'd0) begin errors++;
      $display("FAIL rst_mid after reset got busy=%b done=%b pass=%b drv=%b err=%0d fail=%b want all 0", b, d, p, drv, e_o, f_o); end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) ndone++;
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_mid idle busy cycle %0d got %b want 0", i, busy1); end
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rst_mid done pulses got %0d want 0", ndone); end
    sweep(1, 4'b0111, 4'b0111, 1'b0, 1'b0, "rst_mid_resweep");
  endtask

  task automatic test_random();
    int w;
    logic [3:0] t, g;
    for (int i = 0; i < 8; i++) begin
      w = int'($urandom_range(1, 2));
      t = 4'($urandom_range(0, 15));
      g = ($urandom_range(0, 3) == 0) ? t : 4'($urandom_range(0, 15));
      sweep(w, t, g, 1'b0, 1'b0, "random");
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; truth = 4'b0111; gate_tt = 4'b0111;
    #2;
    test_reset();
    sweep(1, 4'b0111, 4'b0111, 1'b0, 1'b0, "nand");
    sweep(1, 4'b0111, 4'b1111, 1'b0, 1'b0, "stuck1");
    sweep(1, 4'b0111, 4'b1000, 1'b0, 1'b0, "and_gate");
    sweep(1, 4'b0111, 4'b0111, 1'b1, 1'b0, "restart_ignored");
    test_reset_mid();
    sweep(2, 4'b0111, 4'b0111, 1'b0, 1'b1, "hold2");
    sweep(2, 4'b0111, 4'b1000, 1'b0, 1'b0, "hold2_back_to_back");
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
